// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, multi-cycle EX
// holds, taken-branch flushes and saturating event counters.
module hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_RS1addr_i,
  input  logic [4:0]       ID_RS2addr_i,
  input  logic             ID_UseRS1_i,
  input  logic             ID_UseRS2_i,
  input  logic             EX_MemRead_i,
  input  logic [4:0]       EX_RDaddr_i,
  input  logic             EX_Multi_i,
  input  logic             Branch_taken_i,
  output logic             PCWrite_o,
  output logic             IF_ID_Write_o,
  output logic             IF_ID_Flush_o,
  output logic             ID_EX_Bubble_o,
  output logic             EX_Hold_o,
  output logic             MEM_Bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int MW = $clog2(MUL_CYCLES) + 1;
  localparam logic [MW-1:0] LAST = MW'(MUL_CYCLES - 1);

  typedef enum logic {
    RUN  = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [MW-1:0] mcnt;
  logic [MW-1:0] mcnt_nx;
  logic          hold_raw;
  logic          hold;
  logic          rs1_hit;
  logic          rs2_hit;
  logic          lu;
  logic          flush;

  // State and multi-cycle counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= RUN;
      mcnt  <= '0;
    end else begin
      state <= state_nx;
      mcnt  <= mcnt_nx;
    end
  end

  // Next-state logic and raw hold for the multi-cycle op in EX
  always_comb begin
    state_nx = state;
    mcnt_nx  = mcnt;
    hold_raw = 1'b0;
    case (state)
      RUN: begin
        hold_raw = EX_Multi_i;
        if (EX_Multi_i) begin
          state_nx = BUSY;
          mcnt_nx  = MW'(1);
        end
      end
      BUSY: begin
        hold_raw = (mcnt < LAST);
        if (mcnt == LAST) begin
          state_nx = RUN;
          mcnt_nx  = '0;
        end else begin
          mcnt_nx = mcnt + 1'b1;
        end
      end
      default: begin
        state_nx = RUN;
        mcnt_nx  = '0;
      end
    endcase
  end

  // Hazard conditions, already ranked hold > load-use > flush
  always_comb begin
    rs1_hit = ID_UseRS1_i
            && (ID_RS1addr_i == EX_RDaddr_i);
    rs2_hit = ID_UseRS2_i
            && (ID_RS2addr_i == EX_RDaddr_i);
    hold    = !rst_i && hold_raw;
    lu      = !rst_i && !hold
            && EX_MemRead_i
            && (EX_RDaddr_i != 5'd0)
            && (rs1_hit || rs2_hit);
    flush   = !rst_i && !hold && !lu
            && Branch_taken_i;
  end

  // Control output decode; reset forces idle values
  always_comb begin
    PCWrite_o      = 1'b1;
    IF_ID_Write_o  = 1'b1;
    IF_ID_Flush_o  = 1'b0;
    ID_EX_Bubble_o = 1'b0;
    EX_Hold_o      = 1'b0;
    MEM_Bubble_o   = 1'b0;
    unique case (1'b1)
      hold: begin
        PCWrite_o     = 1'b0;
        IF_ID_Write_o = 1'b0;
        EX_Hold_o     = 1'b1;
        MEM_Bubble_o  = 1'b1;
      end
      lu: begin
        PCWrite_o      = 1'b0;
        IF_ID_Write_o  = 1'b0;
        ID_EX_Bubble_o = 1'b1;
      end
      flush: begin
        IF_ID_Flush_o = 1'b1;
      end
      default: begin
        PCWrite_o = 1'b1;
      end
    endcase
  end

  // Saturating stall and flush event counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (!PCWrite_o && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + 1'b1;
      if (IF_ID_Flush_o && (flush_cnt_o != '1))
        flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core.
- Sits opposite the ID/EX pipeline register: it consumes that register's outputs (EX-stage MemRead, RD address, multi-cycle flag) plus the ID-stage source addresses.
- Drives the stall, hold, flush and bubble controls back into PC, IF/ID, ID/EX and EX/MEM.
- Handles load-use stalls, multi-cycle EX ops (iterative multiply) and taken-branch flushes, and keeps saturating stall/flush counters.

Parameters:
MUL_CYCLES  4   cycles a multi-cycle op occupies EX; legal range >= 2
CNT_W       16  width of the stall and flush counters

Ports:
clk_i            in   1      clock, rising edge
rst_i            in   1      reset, synchronous, active-high
ID_RS1addr_i     in   5      rs1 address of the instruction in ID
ID_RS2addr_i     in   5      rs2 address of the instruction in ID
ID_UseRS1_i      in   1      ID instruction reads rs1
ID_UseRS2_i      in   1      ID instruction reads rs2
EX_MemRead_i     in   1      ID/EX MEM control MemRead bit (load in EX)
EX_RDaddr_i      in   5      ID/EX RD address
EX_Multi_i       in   1      instruction in EX is a multi-cycle op
Branch_taken_i   in   1      branch resolved taken in ID
PCWrite_o        out  1      PC update enable
IF_ID_Write_o    out  1      IF/ID load enable
IF_ID_Flush_o    out  1      IF/ID clear to NOP
ID_EX_Bubble_o   out  1      ID/EX loads zero WB/MEM/EX controls
EX_Hold_o        out  1      ID/EX and EX-stage state hold their values
MEM_Bubble_o     out  1      EX/MEM loads zero controls
stall_cnt_o      out  CNT_W  cycles with PCWrite_o=0, saturating
flush_cnt_o      out  CNT_W  cycles with IF_ID_Flush_o=1, saturating

Behaviour:
- Clock and reset: single clock clk_i. Synchronous active-high reset on rst_i.
- State register: RUN / BUSY, plus a cycle counter mcnt (width clog2(MUL_CYCLES)+1).
  - Reset: state=RUN, mcnt=0, stall_cnt_o=0, flush_cnt_o=0.
- Outputs during reset: while rst_i=1, outputs are forced to idle values (PCWrite_o=1, IF_ID_Write_o=1, all others 0).
  - This applies even if rst_i is asserted mid-BUSY; the machine is in RUN on the following cycle.
- Output decode: all control outputs are combinational from state, mcnt and the current inputs (Mealy); there is no added latency.
- Multi-cycle hold:
  - hold = (RUN and EX_Multi_i) or (BUSY and mcnt < MUL_CYCLES-1).
  - RUN with EX_Multi_i=1: go to BUSY, mcnt=1.
  - BUSY: mcnt++ each cycle. When mcnt == MUL_CYCLES-1 this is the op's final EX cycle: hold=0, next state RUN.
  - EX_Multi_i is ignored in BUSY.
  - Hold lasts exactly MUL_CYCLES-1 cycles; MUL_CYCLES=2 gives a 1-cycle hold.
  - While hold: PCWrite_o=0, IF_ID_Write_o=0, EX_Hold_o=1, MEM_Bubble_o=1, ID_EX_Bubble_o=0.
- Load-use stall (evaluated only when hold=0):
  - Condition: lu = EX_MemRead_i and EX_RDaddr_i != 0 and ((ID_UseRS1_i and RS1 match) or (ID_UseRS2_i and RS2 match)).
  - lu: PCWrite_o=0, IF_ID_Write_o=0, ID_EX_Bubble_o=1 for that cycle only.
  - No state is kept; the next cycle the load has moved to MEM and lu drops naturally.
- Branch flush:
  - IF_ID_Flush_o = Branch_taken_i and not hold and not lu.
  - During a stall the branch is frozen in ID and re-evaluated when the stall releases.
- Priority: hold > load-use > branch flush.
- No-hazard outputs: PCWrite_o=1, IF_ID_Write_o=1, all others 0.
- Counters:
  - stall_cnt_o increments every non-reset cycle with PCWrite_o=0.
  - flush_cnt_o increments every cycle with IF_ID_Flush_o=1.
  - Both saturate at 2^CNT_W-1 with no wrap.
- Back-to-back multi-cycle ops: the cycle after BUSY→RUN, EX_Multi_i refers to the new EX instruction. If it is high, hold asserts immediately and BUSY is re-entered.
- RD=x0: never causes a load-use stall.

Test Plan:
- Load-use: EX_MemRead_i=1, EX_RDaddr_i=5, ID_RS2addr_i=5, ID_UseRS2_i=1 for 1 cycle → that cycle PCWrite_o=0, IF_ID_Write_o=0, ID_EX_Bubble_o=1; next cycle (MemRead=0) all idle; stall_cnt_o=1. Repeat with EX_RDaddr_i=0, or ID_UseRS2_i=0 → no stall.
- Multi-cycle, MUL_CYCLES=4: EX_Multi_i=1 held 4 cycles → EX_Hold_o=1, MEM_Bubble_o=1, PCWrite_o=0 on cycles 0-2; cycle 3 idle; state RUN at cycle 4; stall_cnt_o=3.
- Priority: during BUSY hold drive the load-use condition and Branch_taken_i=1 → only the hold outputs assert (ID_EX_Bubble_o=0, IF_ID_Flush_o=0). At release with branch still high → IF_ID_Flush_o=1 for 1 cycle; flush_cnt_o=1.
- Back-to-back: two 4-cycle ops (EX_Multi_i high 8 cycles) → hold on cycles 0-2 and 4-6, idle on 3 and 7; stall_cnt_o=6.
- Reset mid-BUSY: assert rst_i at mcnt=2 → outputs idle that cycle; next cycle RUN, counters 0, EX_Multi_i=0 → no hold.
- Saturation, CNT_W=4: 20 consecutive load-use stall cycles → stall_cnt_o stops at 15.
